// File: rtl/arb_pkg.sv
// Shared types and constants for the four-client round-robin arbiter.
package arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef logic [NUM_REQ-1:0] req_vec_t;

  // Bit i of the result is bit (i + amt) mod NUM_REQ of v.
  function automatic req_vec_t rotr(input req_vec_t v, input logic [ID_W-1:0] amt);
    logic [2*NUM_REQ-1:0] dbl;
    dbl = {v, v} >> amt;
    return dbl[NUM_REQ-1:0];
  endfunction

endpackage

// File: rtl/prio_enc_4to2_lsb.sv
// Combinational 4-to-2 priority encoder: lowest set index wins, valid flags any bit set.
module prio_enc_4to2_lsb
  import arb_pkg::*;
(
  input  req_vec_t        req,
  output logic [ID_W-1:0] idx,
  output logic            valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req[i] && !valid) begin
        idx   = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered one-hot grant and sticky ownership.
// Optional hold-time limit enabled by defining ARB_HOLD_LIMIT_EN.
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_valid
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_range
    $error("rr_arbiter_4: HOLD_MAX must be in 2..255");
  end

  arb_state_t      state, state_n;
  logic [ID_W-1:0] ptr, ptr_n, base, enc_idx, winner, id_n;
  req_vec_t        owner_mask, arb_req, rot_req, grant_n;
  logic            owner_req, hold_expired, keep, enc_valid, valid_n, load;

  always_comb begin
    owner_mask = req_vec_t'(1) << ptr;
    owner_req  = |(req & owner_mask);
    base       = ptr + ID_W'(1);
  end

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] hold_cnt;
  logic       others;

  assign others       = |(req & ~owner_mask);
  assign hold_expired = (state == GRANT) && owner_req && others && (hold_cnt == HOLD_LAST);

  // Counts cycles the current owner has kept the grant; any handover or idle clears it.
  always_ff @(posedge clk) begin
    if (rst || !keep) begin
      hold_cnt <= '0;
    end else if (hold_cnt != HOLD_LAST) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end
`else
  assign hold_expired = 1'b0;
`endif

  assign keep = (state == GRANT) && owner_req && !hold_expired;

  // A revoked owner is masked out so it cannot win its own rotation.
  always_comb begin
    arb_req = hold_expired ? (req & ~owner_mask) : req;
    rot_req = rotr(arb_req, base);
  end

  prio_enc_4to2_lsb u_enc (
    .req   (rot_req),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  assign winner = enc_idx + base;

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    grant_n = grant;
    id_n    = grant_id;
    valid_n = grant_valid;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (enc_valid) load = 1'b1;
      end
      GRANT: begin
        if (!keep) begin
          if (enc_valid) begin
            load = 1'b1;
          end else begin
            state_n = IDLE;
            grant_n = '0;
            id_n    = '0;
            valid_n = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (load) begin
      state_n = GRANT;
      ptr_n   = winner;
      grant_n = req_vec_t'(1) << winner;
      id_n    = winner;
      valid_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 2'd3;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      grant       <= grant_n;
      grant_id    <= id_n;
      grant_valid <= valid_n;
    end
  end

endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Four-requester round-robin arbiter that shares one downstream resource (bus, memory port, encoder output lane) among four clients. It is built around the 4-to-2 priority encoding used elsewhere in the Encoder library. Each cycle it produces a registered one-hot grant, the 2-bit binary ID of the owner, and a valid flag. Grants are sticky while the owner keeps requesting, with an optional hold-time limit that forces rotation.

## Interface
- HOLD_MAX, 8: maximum consecutive grant cycles per owner while others wait. Range 2..255. Used only when ARB_HOLD_LIMIT_EN is defined.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  4  request vector; bit i = client i; a client holds its bit high until done
- grant  output  4  registered one-hot grant; all-zero when idle
- grant_id  output  2  binary index of the granted client; 0 when idle
- grant_valid  output  1  high when grant is non-zero; equals |grant

## Operation
- Reset: grant=4'b0000, grant_id=2'b00, grant_valid=0, state=IDLE, last-owner pointer ptr=2'd3, hold_cnt=0.
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first set bit searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - Register grant/grant_id/grant_valid for the winner, load ptr=winner, clear hold_cnt, go to GRANT.
- State GRANT, owner = ptr:
  - req[ptr]=1 and no forced rotation: keep grant, increment hold_cnt. The counter saturates at HOLD_MAX-1.
  - req[ptr]=0 (release):
    - Other requests pending: re-arbitrate in the same cycle with round-robin order starting at ptr+1, and grant the new winner on the next edge. There is no idle bubble.
    - No requests pending: go to IDLE and clear the outputs.
- Round-robin order is always ptr+1 first, wrapping modulo 4 (3→0). The just-served client has the lowest priority.
- Zero request vector never yields a grant. grant_valid=0 distinguishes "idle" from "client 0 granted".
- X/Z on req: no defined behaviour is required. The bench drives only 0/1.

## Timing
- Latency: request sampled at edge n → grant visible after edge n (one cycle). Request present at reset release → grant one cycle after rst falls.
- Handover: owner drops req at edge n → next owner granted after edge n. Exactly one cycle with the old grant is observed after release.
- Outputs change only on clk edges. No combinational path from req to grant.
- rst asserted mid-grant: all outputs go to their reset values on that edge, and ptr returns to 3.
- Simultaneous release by the owner and a new request: the new request competes in the same arbitration.
- Grant is always one-hot or zero. grant_id always matches grant.

## Configuration
- ARB_HOLD_LIMIT_EN defined:
  - When hold_cnt==HOLD_MAX-1 and any other req bit is set, the next edge revokes the owner and grants the next round-robin requester.
  - A revoked owner still requesting waits its turn.
  - If no other requester is pending, the owner keeps the grant indefinitely and hold_cnt stays saturated.
- ARB_HOLD_LIMIT_EN not defined: no hold counter is built. Grant is held until the owner drops req, and HOLD_MAX is ignored.

## Structure
- Package arb_pkg:
  - NUM_REQ=4 and ID_W=2.
  - Typedef arb_state_t {IDLE, GRANT}.
  - Typedef req_vec_t (logic [3:0]).
- Sub-module prio_enc_4to2_lsb (combinational):
  - Outputs the lowest set index plus valid.
  - The arbiter feeds it req rotated right by ptr+1, then adds ptr+1 mod 4 to the result.
  - The sub-module has no clock.

## Test plan
- Reset, then req=4'b0000 for 5 cycles → grant=0, grant_id=0, grant_valid=0 throughout.
- From reset, req=4'b1111 held; each owner drops req one cycle after its grant → grants cycle 0001, 0010, 0100, 1000, 0001 with grant_id 0,1,2,3,0.
- Owner 2 granted with req=4'b0100, then req changes to 4'b0011 as 2 releases → next grant 4'b0001 (wrap from 3 to 0 precedes 1), grant_id=0.
- rst pulsed while client 3 is granted → outputs zero next edge. Then req=4'b1001 → grant 4'b0001, since ptr reset to 3.
- ARB_HOLD_LIMIT_EN with HOLD_MAX=4: req=4'b0011 held → client 0 granted exactly 4 cycles, then client 1 for 4, then client 0 again.
- ARB_HOLD_LIMIT_EN with HOLD_MAX=4 and req=4'b0001 only → client 0 keeps the grant for 20 cycles without a drop.
